// File: rtl/vec_streamer_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the vector streamer: default widths and the
// sequencing FSM state encoding.
// ---------------------------------------------------------------------------
package vec_pkg;

  localparam int DEF_DATAW = 32;
  localparam int DEF_ADDRW = 9;
  localparam int DEF_LENW  = 10;

  // Output buffer depth; the issue throttle is built around this value.
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } vec_state_t;

endpackage

// File: rtl/vec_streamer_fifo2.sv
// ---------------------------------------------------------------------------
// stream_fifo2
// Two-entry FIFO holding one returned element plus its first/last tags.
// A push is accepted while full only if the head is popped in the same cycle.
//
// Ports
//   clk, rst   clock, synchronous active-high reset (flushes all entries)
//   i_push     write i_data this cycle
//   i_data     payload
//   i_pop      discard the head entry this cycle
//   o_data     head entry (stable until popped)
//   o_full     both entries occupied
//   o_empty    no entries
//   o_count    number of occupied entries (0..2)
// ---------------------------------------------------------------------------
module stream_fifo2 #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_count == 2'd0);
  assign o_full    = (r_count == 2'd2);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // When full the write lands in the slot being vacated by the pop.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vec_streamer.sv
// ---------------------------------------------------------------------------
// vec_streamer
// Reads a vector of cmd_len elements starting at cmd_base from a RAM with a
// one-cycle read latency and streams them out under valid/ready flow
// control, tagging the first and last element.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready high
// ST_ISSUE | issuing RAM reads, throttled so returned data always fits
// ST_DRAIN | all reads issued; waiting for the last element to transfer
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_base, cmd_len first RAM address and element count (0 = no-op)
//   rd_en, rd_addr    RAM read strobe/address (address wraps)
//   rd_data           RAM data, one cycle after rd_en
//   odata, ovalid     element stream out
//   oready            downstream ready
//   ofirst, olast     element is index 0 / index cmd_len-1
//   busy              command in progress or elements still buffered
// ---------------------------------------------------------------------------
module vec_streamer
  import vec_pkg::*;
#(
  parameter int DATAW = DEF_DATAW,
  parameter int ADDRW = DEF_ADDRW,
  parameter int LENW  = DEF_LENW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ADDRW-1:0] cmd_base,
  input  logic [LENW-1:0]  cmd_len,
  output logic             rd_en,
  output logic [ADDRW-1:0] rd_addr,
  input  logic [DATAW-1:0] rd_data,
  output logic [DATAW-1:0] odata,
  output logic             ovalid,
  input  logic             oready,
  output logic             ofirst,
  output logic             olast,
  output logic             busy
);

  localparam int PW = DATAW + 2;

  vec_state_t       r_state;
  vec_state_t       w_state_nxt;

  logic [ADDRW-1:0] r_base;
  logic [LENW-1:0]  r_len;
  logic [LENW-1:0]  r_issue_cnt;

  // One read can be outstanding at a time per cycle of latency; these carry
  // its tags until the data returns.
  logic             r_inflight;
  logic             r_inflight_first;
  logic             r_inflight_last;

  logic             w_cmd_ready;
  logic             w_rd_en;
  logic             w_issue_last;
  logic             w_pop;
  logic             w_push;
  logic [2:0]       w_occ;

  logic [PW-1:0]    w_fifo_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [1:0]       w_fifo_count;

  assign w_issue_last = (r_issue_cnt == (r_len - LENW'(1)));

  assign ovalid = !w_fifo_empty && !rst;
  assign w_pop  = ovalid && oready;

  // Occupancy seen by the next returned element: buffered plus in-flight,
  // less the entry leaving this cycle. Counting the pop is what allows a
  // sustained one element per cycle with a two-deep buffer.
  assign w_occ  = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);

  // The throttle guarantees room; the guard keeps a full buffer intact.
  assign w_push = r_inflight && (!w_fifo_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        // Zero-length commands are consumed without leaving IDLE.
        if (cmd_valid && (cmd_len != '0)) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_rd_en = (w_occ < 3'(FIFO_DEPTH));
        if (w_rd_en && w_issue_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop && w_fifo_head[0]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (rst) begin
      w_cmd_ready = 1'b0;
      w_rd_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base           <= '0;
      r_len            <= '0;
      r_issue_cnt      <= '0;
      r_inflight       <= 1'b0;
      r_inflight_first <= 1'b0;
      r_inflight_last  <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (cmd_valid && w_cmd_ready && (cmd_len != '0)) begin
        r_base      <= cmd_base;
        r_len       <= cmd_len;
        r_issue_cnt <= '0;
      end
      if (w_rd_en) begin
        r_issue_cnt      <= r_issue_cnt + LENW'(1);
        r_inflight_first <= (r_issue_cnt == '0);
        r_inflight_last  <= w_issue_last;
      end
    end
  end

  // Address arithmetic is ADDRW bits wide so it wraps modulo the RAM size.
  assign rd_addr   = r_base + ADDRW'(r_issue_cnt);
  assign rd_en     = w_rd_en;
  assign cmd_ready = w_cmd_ready;

  stream_fifo2 #(
    .W (PW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({rd_data, r_inflight_first, r_inflight_last}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign odata  = w_fifo_head[PW-1:2];
  assign ofirst = w_fifo_head[1] && ovalid;
  assign olast  = w_fifo_head[0] && ovalid;
  assign busy   = !rst && ((r_state != ST_IDLE) || !w_fifo_empty);

endmodule

// File: tb/tb_vec_streamer.sv
module tb_vec_streamer;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_base = '0;
  logic [9:0]  cmd_len = '0;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] odata;
  logic        ovalid;
  logic        oready = 1'b0;
  logic        ofirst;
  logic        olast;
  logic        busy;

  always #5 clk = ~clk;

  vec_streamer #(.DATAW(32), .ADDRW(9), .LENW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .odata     (odata),
    .ovalid    (ovalid),
    .oready    (oready),
    .ofirst    (ofirst),
    .olast     (olast),
    .busy      (busy)
  );

  // RAM with one-cycle read latency; garbage when not reading.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : $urandom;

  typedef struct packed {
    logic [31:0] data;
    logic        first;
    logic        last;
  } elem_t;

  typedef struct {
    logic [8:0] base;
    logic [9:0] len;
    logic [3:0] rpat;
    int         exp_n;
  } vec_t;

  elem_t      exp_q[$];
  logic [8:0] addr_q[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rk = 0;
  int   rmode = 0;
  int   n_xfer = 0;
  int   acc_cyc = 0;
  int   olast_cyc = 0;
  bit   acc_seen = 0;
  bit   m_active = 0;
  bit   prev_stall = 0;
  logic [33:0] prev_out = '0;
  logic [3:0]  rpat = 4'hF;
  logic s_ovalid, s_cmd_ready;
  logic [31:0] s_odata;
  logic [8:0]  s_rd_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at cycle %0d: got event, expected none", name, cyc);
  endtask

  // Sampled on the falling edge; the model is the ordered list of elements
  // and addresses each accepted command must produce.
  task automatic check();
    elem_t e;
    logic [8:0] a;
    cyc++;
    s_ovalid    = ovalid;
    s_cmd_ready = cmd_ready;
    s_odata     = odata;
    s_rd_addr   = rd_addr;
    if (rst) begin
      chk("rst_ovalid", 64'(ovalid), 64'(0));
      chk("rst_rd_en", 64'(rd_en), 64'(0));
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_tags", 64'({ofirst, olast}), 64'(0));
      exp_q.delete();
      addr_q.delete();
      m_active   = 0;
      prev_stall = 0;
      return;
    end
    chk("cmd_ready", 64'(cmd_ready), 64'(!m_active));
    chk("busy", 64'(busy), 64'(m_active));
    if (!m_active) chk("ovalid_idle", 64'(ovalid), 64'(0));
    if (rd_en) begin
      if (addr_q.size() == 0) fail_now("unexpected_rd_en");
      else chk("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
    end
    if (prev_stall) chk("stall_hold", 64'({ovalid, odata, ofirst, olast}), 64'({1'b1, prev_out}));
    if (ovalid && oready) begin
      n_xfer++;
      if (exp_q.size() == 0) fail_now("unexpected_elem");
      else begin
        e = exp_q.pop_front();
        chk("elem", 64'({odata, ofirst, olast}), 64'(e));
        if (e.last) begin
          m_active  = 0;
          olast_cyc = cyc;
        end
      end
    end
    prev_stall = ovalid && !oready;
    prev_out   = {odata, ofirst, olast};
    if (cmd_valid && cmd_ready) begin
      acc_seen = 1;
      acc_cyc  = cyc;
      for (int i = 0; i < int'(cmd_len); i++) begin
        a = 9'((int'(cmd_base) + i) % DEPTH);
        e.data  = mem[a];
        e.first = (i == 0);
        e.last  = (i == int'(cmd_len) - 1);
        exp_q.push_back(e);
        addr_q.push_back(a);
      end
      if (cmd_len != 0) m_active = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    rk++;
    oready = (rmode != 0) ? ($urandom_range(0, 3) != 0) : rpat[rk[1:0]];
  endtask

  task automatic send(input logic [8:0] base, input logic [9:0] len);
    cmd_base  = base;
    cmd_len   = len;
    cmd_valid = 1'b1;
    acc_seen  = 0;
    for (int i = 0; i < 200 && !acc_seen; i++) tick();
    cmd_valid = 1'b0;
    chk("accepted", 64'(acc_seen), 64'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (m_active || exp_q.size() != 0); i++) tick();
    chk("drained", 64'({m_active, exp_q.size() != 0}), 64'(0));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ovalid", 64'(s_ovalid), 64'(0));
    chk("post_rst_cmd_ready", 64'(s_cmd_ready), 64'(1));
    chk("post_rst_odata", 64'(s_odata), 64'(0));
    chk("post_rst_rd_addr", 64'(s_rd_addr), 64'(0));
  endtask

  vec_t tbl[8];

  initial begin
    int lat;
    int run;
    tbl[0] = '{9'd5,   10'd4,  4'b1111, 4};
    tbl[1] = '{9'd0,   10'd1,  4'b1111, 1};
    tbl[2] = '{9'd0,   10'd0,  4'b1111, 0};
    tbl[3] = '{9'd0,   10'd6,  4'b1001, 6};
    tbl[4] = '{9'd510, 10'd4,  4'b1111, 4};
    tbl[5] = '{9'd100, 10'd7,  4'b0101, 7};
    tbl[6] = '{9'd511, 10'd3,  4'b0010, 3};
    tbl[7] = '{9'd20,  10'd10, 4'b1110, 10};

    for (int a = 0; a < DEPTH; a++) mem[a] = 32'(a * 10);
    mem[0] = 32'hFFFF_FFF9;

    rpat  = 4'hF;
    oready = 1'b1;
    do_reset(3);

    // Table of commands with fixed ready patterns.
    foreach (tbl[k]) begin
      rk     = 0;
      rpat   = tbl[k].rpat;
      n_xfer = 0;
      send(tbl[k].base, tbl[k].len);
      drain();
      tick();
      tick();
      chk("n_xfer", 64'(n_xfer), 64'(tbl[k].exp_n));
      if (tbl[k].len == 0) chk("len0_ready", 64'(s_cmd_ready), 64'(1));
    end

    // Latency and streaming rate with ready held high: ovalid shows up after
    // the second edge following the accepting edge, then every cycle.
    rpat = 4'hF;
    oready = 1'b1;
    send(9'd5, 10'd4);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (s_ovalid) break;
    end
    chk("first_latency", 64'(lat), 64'(3));
    run = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s_ovalid) run++;
    end
    chk("throughput", 64'(run), 64'(4));
    drain();

    // Back-to-back commands: next accepted the cycle after olast transfers.
    send(9'd40, 10'd3);
    send(9'd60, 10'd2);
    chk("b2b_gap", 64'(acc_cyc - olast_cyc), 64'(1));
    drain();
    tick();

    // Reset in the middle of an 8-element vector after 3 transfers.
    n_xfer = 0;
    send(9'd100, 10'd8);
    for (int i = 0; i < 50 && n_xfer < 3; i++) tick();
    chk("pre_rst_xfers", 64'(n_xfer), 64'(3));
    do_reset(1);
    n_xfer = 0;
    send(9'd7, 10'd2);
    drain();
    chk("post_rst_xfers", 64'(n_xfer), 64'(2));

    // Randomised commands, data and backpressure.
    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
    rmode = 1;
    for (int k = 0; k < 25; k++) begin
      send(9'($urandom_range(0, DEPTH - 1)), 10'($urandom_range(0, 12)));
      if ($urandom_range(0, 2) != 0) drain();
    end
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/vec_streamer.md
VEC_STREAMER -- requirements
Module: vec_streamer

Interface
REQ-001 Parameter DATAW, default 32, element bitwidth.
REQ-002 Parameter ADDRW, default 9, vector RAM address width.
REQ-003 Parameter LENW, default 10, command length width (max length 2^LENW-1).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
REQ-008 cmd_base  input  ADDRW  first RAM address of vector.
REQ-009 cmd_len  input  LENW  element count.
REQ-010 rd_en  output  1  RAM read strobe.
REQ-011 rd_addr  output  ADDRW  RAM read address.
REQ-012 rd_data  input  DATAW  RAM data, valid exactly 1 cycle after rd_en.
REQ-013 odata  output  DATAW  signed element out.
REQ-014 ovalid  output  1  element valid.
REQ-015 oready  input  1  downstream accepts; transfer = ovalid&&oready.
REQ-016 ofirst  output  1  element is vector index 0.
REQ-017 olast  output  1  element is vector index cmd_len-1.
REQ-018 busy  output  1  command in progress or elements still buffered.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, DRAIN; cmd_ready SHALL be 1 only in IDLE.
REQ-020 Accepting a command with cmd_len>0 SHALL latch base/len, zero the issue counter, and enter ISSUE.
REQ-021 Accepting cmd_len=0 SHALL emit nothing, stay in IDLE, and keep busy=0.
REQ-022 In ISSUE, rd_en SHALL assert when (buffered entries + in-flight reads) < 2; rd_addr = base + issue count, wrapping modulo 2^ADDRW.
REQ-023 After issuing the read for index len-1, FSM SHALL enter DRAIN; DRAIN->IDLE when the element tagged olast transfers.
REQ-024 Returned rd_data SHALL enter a 2-entry FIFO tagged with first (index 0) and last (index len-1); a single-element vector SHALL have ofirst=olast=1.
REQ-025 FIFO head SHALL drive odata/ofirst/olast; ovalid = FIFO non-empty.
REQ-026 odata/ofirst/olast SHALL remain stable while ovalid&&!oready.
REQ-027 Elements SHALL be emitted in index order, none dropped or duplicated, under any oready pattern.
REQ-028 With oready held 1, throughput SHALL be 1 element/cycle; first ovalid 2 cycles after command acceptance.
REQ-029 Simultaneous FIFO push and pop SHALL be legal when full or empty.
REQ-030 busy = (state != IDLE) || FIFO non-empty.
REQ-031 Next command SHALL be acceptable the cycle after olast transfers (back-to-back vectors, one-cycle gap).

Reset
REQ-032 On rst: state IDLE, ovalid=0, ofirst=0, olast=0, rd_en=0, busy=0, cmd_ready=0 during rst and 1 the cycle after.
REQ-033 rst mid-vector SHALL flush FIFO and in-flight read; rd_data arriving the cycle after rst SHALL be discarded.
REQ-034 odata and rd_addr reset value SHALL be 0.

Structure
REQ-035 Shared package vec_pkg SHALL hold the FSM state enum and default DATAW/ADDRW/LENW constants.
REQ-036 The 2-entry FIFO SHALL be sub-module stream_fifo2 (payload DATAW+2 bits, push/pop/full/empty/count).

Verification
REQ-037 base=5,len=4, RAM[a]=a*10, oready=1 -> odata 50,60,70,80 consecutive cycles, ofirst on 50, olast on 80.
REQ-038 len=1, base=0, RAM[0]=-7 -> one element -7 with ofirst=olast=1, busy low next cycle.
REQ-039 len=0 -> no ovalid, no rd_en, cmd_ready stays 1.
REQ-040 len=6, oready toggling 1,0,0,1,... -> 6 in-order elements, data stable when stalled, FIFO never overflows.
REQ-041 base=2^ADDRW-2, len=4 -> rd_addr sequence 510,511,0,1 (ADDRW=9).
REQ-042 rst asserted mid vector len=8 after 3 transfers -> ovalid=0 next cycle, new command len=2 streams correctly with ofirst/olast.
